operand_fetch_stage: RTL
========================

OPERAND_FETCH_STAGE -- requirements
Module: operand_fetch_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 64, datapath width of operands and immediate.
REQ-002 SHALL have parameter XZR, default 5'd31, zero register index that never hazards.
REQ-003 SHALL have ports: clk  input  1  clock; reset_n  input  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports: id_valid  input  1  decode slot valid; id_rn, id_rm, id_rd  input  5 each  source/dest registers; id_rdata1, id_rdata2  input  DATA_W  register-file read data; id_imm  input  DATA_W  extended immediate; id_ctrl  input  ctrl_t  RegWrite, MemRead, MemWrite, ALUSrc, ALUOp[2:0].
REQ-005 SHALL have ports: forward1, forward2  input  1  bypass select; forward_data1, forward_data2  input  DATA_W  bypass values; flush  input  1  branch-taken squash.
REQ-006 SHALL have ports: ex_valid  output  1; ex_rd  output  5; ex_opA, ex_opB  output  DATA_W; ex_store_data  output  DATA_W; ex_ctrl  output  ctrl_t; stall  output  1  holds PC and decode register.

Function
REQ-007 SHALL select operand A = forward1 ? forward_data1 : id_rdata1; raw B = forward2 ? forward_data2 : id_rdata2.
REQ-008 SHALL register ex_opA = A, ex_opB = ALUSrc ? id_imm : raw B, ex_store_data = raw B; one-cycle latency from decode to outputs.
REQ-009 SHALL detect load-use hazard when ex_valid & ex_ctrl.MemRead & ex_rd != XZR & id_valid & (ex_rd == id_rn | ex_rd == id_rm).
REQ-010 SHALL implement FSM RUN/BUBBLE; RUN->BUBBLE on hazard & !flush; BUBBLE->RUN unconditionally next cycle.
REQ-011 SHALL assert stall combinationally in RUN when hazard & !flush; stall = 0 in BUBBLE.
REQ-012 SHALL on hazard load ex_valid = 0 and ex_ctrl = all-zero (bubble); other data outputs don't-care.
REQ-013 SHALL on flush load bubble regardless of hazard or state and return to RUN; flush wins over stall.
REQ-014 SHALL on id_valid = 0 load a bubble.
REQ-015 SHALL never assert stall for two consecutive cycles for the same instruction.

Reset
REQ-016 SHALL on reset_n low asynchronously clear ex_valid, ex_rd, ex_opA, ex_opB, ex_store_data, ex_ctrl to 0, FSM to RUN; stall reads 0.
REQ-017 SHALL on reset mid-BUBBLE return to RUN with no pending stall after release.

Configuration
REQ-018 SHALL, with STALL_COUNT_EN defined, provide output stall_count  32 bits, incremented on each cycle stall = 1, saturating at 32'hFFFF_FFFF, reset to 0.
REQ-019 SHALL, without STALL_COUNT_EN, omit stall_count port and counter logic entirely.

Structure
REQ-020 SHALL take ctrl_t struct, ALUOp encodings and XZR constant from shared package cpu_pkg.
REQ-021 SHALL place load-use compare in combinational sub-module hazard_detect; FSM and pipeline register in the top.

Verification
REQ-022 Reset: reset_n = 0 with id_valid = 1 -> all outputs 0, stall 0.
REQ-023 Forward: id_rn = 1, forward1 = 1, forward_data1 = 64'hDEAD, id_rdata1 = 0 -> next cycle ex_opA = 64'hDEAD; forward1 = 0 -> ex_opA = id_rdata1.
REQ-024 Load-use: ex holds LDUR X2 (MemRead, ex_rd = 2), id_rm = 2 -> stall = 1 one cycle, ex_valid = 0 next, then instruction issues with stall = 0.
REQ-025 XZR: ex_rd = 31 with MemRead, id_rn = 31 -> stall = 0, no bubble.
REQ-026 Flush+hazard same cycle -> stall = 0, ex_valid = 0, FSM RUN; with STALL_COUNT_EN, stall_count unchanged.
REQ-027 ALUSrc = 1, id_imm = 64'd8, id_rdata2 = 64'd5 -> ex_opB = 8, ex_store_data = 5.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types: control bundle, ALU opcodes, zero-register index and
// the operand-fetch FSM state encoding.
package cpu_pkg;

  typedef enum logic [2:0] {
    AluAdd   = 3'd0,
    AluSub   = 3'd1,
    AluAnd   = 3'd2,
    AluOrr   = 3'd3,
    AluEor   = 3'd4,
    AluPassB = 3'd5,
    AluLsl   = 3'd6,
    AluLsr   = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    alu_src;
    alu_op_e alu_op;
  } ctrl_t;

  localparam logic [4:0] XZR_IDX  = 5'd31;
  localparam ctrl_t      CTRL_NOP = '0;

  typedef enum logic [0:0] {
    StRun    = 1'b0,
    StBubble = 1'b1
  } of_state_e;

  // True when a load's destination feeds the given source register.
  function automatic logic load_dep(input logic [4:0] ld_rd, input logic [4:0] src,
                                    input logic [4:0] zero_idx);
    return (ld_rd != zero_idx) && (ld_rd == src);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: an in-flight load in EX whose destination
// is read by the instruction currently in decode.
module hazard_detect
  import cpu_pkg::*;
#(
  parameter logic [4:0] XZR = XZR_IDX
) (
  input  logic       ex_valid_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  input  logic       id_valid_i,
  input  logic [4:0] id_rn_i,
  input  logic [4:0] id_rm_i,
  output logic       hazard_o
);

  logic ex_is_load;
  logic src_match;

  always_comb begin
    ex_is_load = ex_valid_i && ex_mem_read_i;
    src_match  = load_dep(ex_rd_i, id_rn_i, XZR) || load_dep(ex_rd_i, id_rm_i, XZR);
    hazard_o   = ex_is_load && id_valid_i && src_match;
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch / ID->EX pipeline register with bypass muxing and a
// one-cycle load-use stall FSM. Define STALL_COUNT_EN to add stall_count.
module operand_fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter logic [4:0]  XZR    = XZR_IDX
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [4:0]        id_rn,
  input  logic [4:0]        id_rm,
  input  logic [4:0]        id_rd,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  ctrl_t             id_ctrl,
  input  logic              forward1,
  input  logic              forward2,
  input  logic [DATA_W-1:0] forward_data1,
  input  logic [DATA_W-1:0] forward_data2,
  input  logic              flush,
  output logic              ex_valid,
  output logic [4:0]        ex_rd,
  output logic [DATA_W-1:0] ex_opA,
  output logic [DATA_W-1:0] ex_opB,
  output logic [DATA_W-1:0] ex_store_data,
  output ctrl_t             ex_ctrl,
  output logic              stall
`ifdef STALL_COUNT_EN
  ,
  output logic [31:0]       stall_count
`endif
);

  of_state_e         state_q, state_d;
  logic              hazard;
  logic              bubble;

  logic              ex_valid_q, ex_valid_d;
  logic [4:0]        ex_rd_q, ex_rd_d;
  logic [DATA_W-1:0] ex_opa_q, ex_opa_d;
  logic [DATA_W-1:0] ex_opb_q, ex_opb_d;
  logic [DATA_W-1:0] ex_store_q, ex_store_d;
  ctrl_t             ex_ctrl_q, ex_ctrl_d;

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] raw_b;

  hazard_detect #(
    .XZR (XZR)
  ) u_hazard_detect (
    .ex_valid_i    (ex_valid_q),
    .ex_mem_read_i (ex_ctrl_q.mem_read),
    .ex_rd_i       (ex_rd_q),
    .id_valid_i    (id_valid),
    .id_rn_i       (id_rn),
    .id_rm_i       (id_rm),
    .hazard_o      (hazard)
  );

  // Flush wins over stall; BUBBLE always returns to RUN after one cycle.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    unique case (state_q)
      StRun: begin
        if (hazard && !flush) begin
          stall   = 1'b1;
          state_d = StBubble;
        end
      end
      StBubble: state_d = StRun;
      default:  state_d = StRun;
    endcase
  end

  always_comb begin
    op_a  = forward1 ? forward_data1 : id_rdata1;
    raw_b = forward2 ? forward_data2 : id_rdata2;
  end

  // Data fields load unconditionally; only valid/ctrl are forced on a bubble.
  always_comb begin
    bubble     = flush || !id_valid || stall;
    ex_valid_d = !bubble;
    ex_ctrl_d  = bubble ? CTRL_NOP : id_ctrl;
    ex_rd_d    = id_rd;
    ex_opa_d   = op_a;
    ex_opb_d   = id_ctrl.alu_src ? id_imm : raw_b;
    ex_store_d = raw_b;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StRun;
      ex_valid_q <= 1'b0;
      ex_rd_q    <= '0;
      ex_opa_q   <= '0;
      ex_opb_q   <= '0;
      ex_store_q <= '0;
      ex_ctrl_q  <= CTRL_NOP;
    end else begin
      state_q    <= state_d;
      ex_valid_q <= ex_valid_d;
      ex_rd_q    <= ex_rd_d;
      ex_opa_q   <= ex_opa_d;
      ex_opb_q   <= ex_opb_d;
      ex_store_q <= ex_store_d;
      ex_ctrl_q  <= ex_ctrl_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_rd         = ex_rd_q;
  assign ex_opA        = ex_opa_q;
  assign ex_opB        = ex_opb_q;
  assign ex_store_data = ex_store_q;
  assign ex_ctrl       = ex_ctrl_q;

`ifdef STALL_COUNT_EN
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`endif

endmodule
